// File: rtl/uart_apb_pkg.sv
// rtl/uart_apb_pkg.sv - shared FSM state, UART register offsets and CTRL field positions
package uart_apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   localparam int REG_UART_DATA = 'h0;
   localparam int REG_UART_CTRL = 'h4;
   localparam int REG_UART_STAT = 'h8;
   localparam int REG_UART_INT  = 'hC;

   localparam int CTRL_EN_SYS       = 0;
   localparam int CTRL_IE           = 1;
   localparam int CTRL_CLK_FREQ_LSB = 2;
   localparam int CTRL_CLK_FREQ_MSB = 3;
   localparam int CTRL_BAUD_LSB     = 4;
   localparam int CTRL_BAUD_MSB     = 6;
   localparam int CTRL_TX_EN        = 7;

endpackage

// File: rtl/uart_apb_master_if.sv
// rtl/uart_apb_master_if.sv - APB bus between the command-driven requester and the UART slave
interface uart_apb_master_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] PADDR;
   logic                  PSELx;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic                  PREADY;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PSLVERR;

   modport master (
      output PADDR, PSELx, PENABLE, PWRITE, PWDATA,
      input  PREADY, PRDATA, PSLVERR
   );

   modport slave (
      input  PADDR, PSELx, PENABLE, PWRITE, PWDATA,
      output PREADY, PRDATA, PSLVERR
   );
endinterface

// File: rtl/uart_apb_master.sv
// rtl/uart_apb_master.sv - command/response stream to APB SETUP/ACCESS requester; optional ACCESS timeout under APB_TIMEOUT_EN
module uart_apb_master
   import uart_apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic                  cmd_write,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   uart_apb_master_if.master     apb,
   output logic                  busy
);

   apb_state_e state;

`ifdef APB_TIMEOUT_EN
   // Abort fires on the wait cycle in which the count would reach TIMEOUT_CYCLES.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] wait_cnt;
   logic       timeout_q;
   assign rsp_timeout = timeout_q;
`else
   assign rsp_timeout = 1'b0;
`endif

   // Only one transfer in flight: commands are taken only while idle.
   assign cmd_ready = (state == IDLE);

   // Transfer sequencer: all APB and response outputs are registered here.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state       <= IDLE;
         apb.PADDR   <= '0;
         apb.PSELx   <= 1'b0;
         apb.PENABLE <= 1'b0;
         apb.PWRITE  <= 1'b0;
         apb.PWDATA  <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         busy        <= 1'b0;
`ifdef APB_TIMEOUT_EN
         wait_cnt    <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  apb.PADDR  <= cmd_addr;
                  apb.PWRITE <= cmd_write;
                  apb.PWDATA <= cmd_write ? cmd_wdata : '0;
                  apb.PSELx  <= 1'b1;
                  busy       <= 1'b1;
                  state      <= SETUP;
               end
            end
            SETUP: begin
               apb.PENABLE <= 1'b1;
`ifdef APB_TIMEOUT_EN
               wait_cnt    <= '0;
`endif
               state       <= ACCESS;
            end
            ACCESS: begin
               if (apb.PREADY) begin
                  rsp_rdata   <= apb.PWRITE ? '0 : apb.PRDATA;
                  rsp_err     <= apb.PSLVERR;
                  apb.PSELx   <= 1'b0;
                  apb.PENABLE <= 1'b0;
                  rsp_valid   <= 1'b1;
                  state       <= RESP;
               end
`ifdef APB_TIMEOUT_EN
               else if (wait_cnt == WAIT_LAST) begin
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b1;
                  timeout_q   <= 1'b1;
                  apb.PSELx   <= 1'b0;
                  apb.PENABLE <= 1'b0;
                  rsp_valid   <= 1'b1;
                  state       <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
`endif
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
                  timeout_q <= 1'b0;
`endif
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_apb_master.sv
// tb/tb_uart_apb_master.sv - directed self-checking bench for uart_apb_master
module tb_uart_apb_master;
   import uart_apb_pkg::*;

   localparam int AW = 4;
   localparam int DW = 8;

   logic          PCLK = 1'b0;
   logic          PRESETn;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr;
   logic          cmd_write;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          rsp_timeout;
   logic          busy;

   int checks = 0;
   int errors = 0;

   uart_apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb_bus ();

   uart_apb_master #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .PCLK       (PCLK),
      .PRESETn    (PRESETn),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_addr   (cmd_addr),
      .cmd_write  (cmd_write),
      .cmd_wdata  (cmd_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .rsp_timeout(rsp_timeout),
      .apb        (apb_bus),
      .busy       (busy)
   );

   always #5 PCLK = ~PCLK;

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic issue(input int addr, input logic wr, input logic [DW-1:0] wd);
      cmd_valid = 1'b1;
      cmd_addr  = AW'(addr);
      cmd_write = wr;
      cmd_wdata = wd;
      check("accept_ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      PRESETn         = 1'b1;
      cmd_valid       = 1'b0;
      cmd_addr        = '0;
      cmd_write       = 1'b0;
      cmd_wdata       = '0;
      rsp_ready       = 1'b1;
      apb_bus.PREADY  = 1'b1;
      apb_bus.PRDATA  = '0;
      apb_bus.PSLVERR = 1'b0;
      #1 PRESETn = 1'b0;
      #2;
      check("rst_psel",    apb_bus.PSELx, 0);
      check("rst_penable", apb_bus.PENABLE, 0);
      check("rst_paddr",   apb_bus.PADDR, 0);
      check("rst_pwdata",  apb_bus.PWDATA, 0);
      check("rst_pwrite",  apb_bus.PWRITE, 0);
      check("rst_rsp",     {rsp_valid, rsp_err, rsp_timeout}, 0);
      check("rst_busy",    busy, 0);
      check("rst_ready",   cmd_ready, 1);
      tick();
      tick();
      PRESETn = 1'b1;
      tick();

      // Write CTRL = tx_en | en_sys with zero wait states
      issue(REG_UART_CTRL, 1'b1, DW'((1 << CTRL_TX_EN) | (1 << CTRL_EN_SYS)));
      check("wr_setup_psel",    apb_bus.PSELx, 1);
      check("wr_setup_penable", apb_bus.PENABLE, 0);
      check("wr_setup_paddr",   apb_bus.PADDR, 4'h4);
      check("wr_setup_pwdata",  apb_bus.PWDATA, 8'h81);
      check("wr_setup_pwrite",  apb_bus.PWRITE, 1);
      check("wr_setup_ready",   cmd_ready, 0);
      check("wr_setup_busy",    busy, 1);
      tick();
      check("wr_access", {apb_bus.PSELx, apb_bus.PENABLE}, 2'b11);
      check("wr_access_rspv", rsp_valid, 0);
      tick();
      check("wr_rsp_valid", rsp_valid, 1);
      check("wr_rsp_err",   rsp_err, 0);
      check("wr_rsp_rdata", rsp_rdata, 0);
      check("wr_rsp_psel",  {apb_bus.PSELx, apb_bus.PENABLE}, 2'b00);
      tick();
      check("wr_idle_ready", cmd_ready, 1);
      check("wr_idle_rspv",  rsp_valid, 0);

      // Read STAT with 3 wait cycles; PSLVERR pulses while not ready are ignored
      apb_bus.PREADY = 1'b0;
      issue(REG_UART_STAT, 1'b0, 8'hEE);
      check("rd_setup_pwdata", apb_bus.PWDATA, 0);
      check("rd_setup_pwrite", apb_bus.PWRITE, 0);
      apb_bus.PSLVERR = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         check("rd_wait_sel",  {apb_bus.PSELx, apb_bus.PENABLE}, 2'b11);
         check("rd_wait_addr", apb_bus.PADDR, 4'h8);
         tick();
      end
      apb_bus.PREADY  = 1'b1;
      apb_bus.PSLVERR = 1'b0;
      apb_bus.PRDATA  = 8'h21;
      check("rd_last_sel",  {apb_bus.PSELx, apb_bus.PENABLE}, 2'b11);
      check("rd_last_addr", apb_bus.PADDR, 4'h8);
      tick();
      check("rd_rsp_valid", rsp_valid, 1);
      check("rd_rsp_rdata", rsp_rdata, 8'h21);
      check("rd_rsp_err",   rsp_err, 0);
      tick();

      // Read 0x2 completing with a slave error
      apb_bus.PSLVERR = 1'b1;
      apb_bus.PRDATA  = 8'h00;
      issue(2, 1'b0, 8'h00);
      tick();
      tick();
      check("err_rsp_valid",   rsp_valid, 1);
      check("err_rsp_err",     rsp_err, 1);
      check("err_rsp_timeout", rsp_timeout, 0);
      check("err_rsp_rdata",   rsp_rdata, 0);
      apb_bus.PSLVERR = 1'b0;
      tick();
      check("err_cleared", {rsp_valid, rsp_err}, 2'b00);

      // Response backpressure with a second command waiting
      rsp_ready = 1'b0;
      issue(REG_UART_DATA, 1'b1, 8'h5A);
      tick();
      tick();
      check("bp_rsp_valid", rsp_valid, 1);
      cmd_valid = 1'b1;
      cmd_addr  = AW'(REG_UART_INT);
      cmd_write = 1'b0;
      cmd_wdata = 8'h00;
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_valid", rsp_valid, 1);
         check("bp_hold_rsp",   {rsp_err, rsp_timeout, rsp_rdata}, 0);
         check("bp_cmd_ready",  cmd_ready, 0);
         check("bp_psel",       apb_bus.PSELx, 0);
         check("bp_paddr",      apb_bus.PADDR, 4'h0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      check("bp_idle_rspv",  rsp_valid, 0);
      check("bp_idle_ready", cmd_ready, 1);
      apb_bus.PRDATA = 8'h3C;
      tick();
      cmd_valid = 1'b0;
      check("bp_second_psel",  apb_bus.PSELx, 1);
      check("bp_second_paddr", apb_bus.PADDR, 4'hC);
      check("bp_second_write", apb_bus.PWRITE, 0);
      tick();
      tick();
      check("bp_second_rdata", rsp_rdata, 8'h3C);
      tick();
      check("idle_retain_paddr", apb_bus.PADDR, 4'hC);

`ifdef APB_TIMEOUT_EN
      // Slave never ready: abort after 4 wait cycles
      apb_bus.PREADY = 1'b0;
      issue(REG_UART_STAT, 1'b0, 8'h00);
      tick();
      for (int i = 0; i < 4; i++) begin
         check("to_wait_sel", {apb_bus.PSELx, apb_bus.PENABLE}, 2'b11);
         tick();
      end
      check("to_rsp_valid",   rsp_valid, 1);
      check("to_rsp_err",     rsp_err, 1);
      check("to_rsp_timeout", rsp_timeout, 1);
      check("to_rsp_rdata",   rsp_rdata, 0);
      check("to_psel",        {apb_bus.PSELx, apb_bus.PENABLE}, 2'b00);
      tick();
      check("to_cleared", {rsp_valid, rsp_err, rsp_timeout}, 0);
      apb_bus.PREADY = 1'b1;
`endif

      // Reset pulse in the middle of ACCESS
      apb_bus.PREADY = 1'b0;
      issue(REG_UART_CTRL, 1'b1, 8'h11);
      tick();
      check("rr_in_access", {apb_bus.PSELx, apb_bus.PENABLE}, 2'b11);
      #1 PRESETn = 1'b0;
      #1;
      check("rr_async_sel",   {apb_bus.PSELx, apb_bus.PENABLE}, 2'b00);
      check("rr_async_paddr", apb_bus.PADDR, 0);
      check("rr_async_pwdat", apb_bus.PWDATA, 0);
      check("rr_async_busy",  busy, 0);
      check("rr_async_ready", cmd_ready, 1);
      #1 PRESETn = 1'b1;
      apb_bus.PREADY = 1'b1;
      tick();
      check("rr_after_ready", cmd_ready, 1);
      check("rr_after_rspv",  rsp_valid, 0);
      tick();
      check("rr_after_rspv2", rsp_valid, 0);
      check("rr_after_psel",  apb_bus.PSELx, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_apb_master.md
Name: uart_apb_master

Overview:
APB requester that converts a simple valid/ready command stream into APB SETUP/ACCESS transfers toward the UART register map. It drives the UART's APB slave port at offsets DATA 0x0, CTRL 0x4, STAT 0x8 and INT 0xC. It returns read data and error status on a valid/ready response channel. It sits between a CPU-side or test-sequencer command source and the UART APB slave.

Parameters:
ADDR_WIDTH, 4, APB address width; must match the slave.
DATA_WIDTH, 8, APB data width (8/16/32).
TIMEOUT_CYCLES, 16, ACCESS-phase wait cycles before abort; used only with APB_TIMEOUT_EN; range 1..255.

Ports:
PCLK  in  1  APB clock
PRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted this cycle when high with cmd_valid
cmd_addr  in  ADDR_WIDTH  target register offset
cmd_write  in  1  1 = write, 0 = read
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_err  out  1  PSLVERR sampled, or timeout
rsp_timeout  out  1  transfer aborted by timeout
PADDR  out  ADDR_WIDTH  APB address
PSELx  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PREADY  in  1  slave ready
PRDATA  in  DATA_WIDTH  slave read data
PSLVERR  in  1  slave error
busy  out  1  state != IDLE

Behaviour:
- Reset (async, PRESETn low): state IDLE; every output register is 0, including PADDR, PWDATA, PWRITE, PSELx, PENABLE, rsp_* and busy. cmd_ready is combinational and therefore 1 in IDLE.
- FSM states are IDLE, SETUP, ACCESS and RESP. All APB outputs are registered.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch the command, load PADDR/PWRITE/PWDATA (PWDATA = 0 for reads), set PSELx = 1 and go to SETUP.
- SETUP (exactly 1 cycle): PSELx = 1, PENABLE = 0. Next state is ACCESS with PENABLE = 1.
- ACCESS: PSELx = 1, PENABLE = 1. Stay while PREADY = 0. When PREADY = 1:
  - Capture PRDATA into rsp_rdata for reads; use 0 for writes.
  - Capture PSLVERR into rsp_err.
  - Drop PSELx and PENABLE, set rsp_valid = 1 and go to RESP.
- PSLVERR is sampled only in the cycle where ACCESS and PREADY are both high. The slave's rx_error pulses outside that cycle are ignored.
- RESP:
  - Hold rsp_* stable while rsp_ready = 0.
  - On rsp_ready, clear rsp_valid, rsp_err and rsp_timeout, then go to IDLE.
  - rsp_rdata retains its value.
- cmd_ready = 0 in SETUP, ACCESS and RESP. There is one outstanding transfer at a time and no command queueing.
- Minimum latency: accept at cycle N, SETUP at N+1, ACCESS at N+2, rsp_valid at N+3. With rsp_ready tied high, the next accept is at N+4.
- PADDR, PWRITE and PWDATA stay stable from SETUP through the end of ACCESS. In IDLE they retain the last transfer's values.
- Wait states are unbounded without the optional feature.
- A reset mid-transfer aborts immediately and the response is lost. PSELx and PENABLE go low asynchronously.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY = 0.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0, abort: PSELx = PENABLE = 0, rsp_rdata = 0, rsp_err = 1, rsp_timeout = 1, go to RESP.
  - PREADY = 1 in the same cycle as expiry wins, and the transfer completes normally.
- Undefined: no counter exists, rsp_timeout is tied 0, and ACCESS waits indefinitely.

Decomposition:
- Shared package uart_apb_pkg:
  - FSM state enum (IDLE/SETUP/ACCESS/RESP).
  - Register offsets REG_UART_DATA 0x0, REG_UART_CTRL 0x4, REG_UART_STAT 0x8, REG_UART_INT 0xC.
  - CTRL field bit positions: en_sys 0, IE 1, clk_freq 3:2, baud 6:4, tx_en 7.
- No sub-module. The FSM and timeout counter stay in one module.

Test Plan:
- Write CTRL 0x4 = 0x81 with PREADY tied 1:
  - SETUP at N+1 with PSELx = 1, PENABLE = 0, PADDR = 0x4, PWDATA = 0x81.
  - ACCESS at N+2.
  - rsp_valid at N+3 with rsp_err = 0, rsp_rdata = 0.
- Read STAT 0x8 with PREADY low for 3 ACCESS cycles, then high with PRDATA = 0x21:
  - PSELx/PENABLE held for 4 ACCESS cycles with address stable.
  - rsp_rdata = 0x21, rsp_err = 0.
- Read 0x2 with the slave asserting PSLVERR and PRDATA = 0x00 at completion: rsp_err = 1, rsp_timeout = 0.
- Response backpressure:
  - rsp_ready low for 5 cycles after rsp_valid: rsp_* stable, cmd_ready = 0, a second cmd_valid is not accepted.
  - rsp_ready high: IDLE next cycle and the second command is accepted.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES = 4 and PREADY stuck 0: abort after 4 wait cycles with rsp_err = 1, rsp_timeout = 1, PSELx = 0.
- Reset pulse during ACCESS: all outputs 0 asynchronously, cmd_ready = 1 after release, no rsp_valid.
